// File: rtl/bespoke_pkg.sv
// Shared types and sizing helpers for the ReLU stage.
// The leaky variant is selected by defining RELU_LEAKY_EN.
package bespoke_pkg;

    typedef logic signed [7:0] int8_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCEPT = 1'b1
    } relu_state_t;

    function automatic int chunks_per_vec(input int vec_len, input int lanes);
        return vec_len / lanes;
    endfunction

endpackage

// File: rtl/chunk_fifo.sv
// Synchronous chunk FIFO with async active-high reset.
// Head entry is always visible on dout; Depth must be a power of two.
module chunk_fifo #(
    parameter int Width = 65,
    parameter int Depth = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  logic [Width-1:0]           din,
    input  logic                       pop,
    output logic [Width-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(Depth));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/relu_stage.sv
// Elementwise (optionally leaky) ReLU stage with chunk FIFO and vector tagging.
// Define RELU_LEAKY_EN to shift negative lanes by LeakShift instead of zeroing.
module relu_stage
    import bespoke_pkg::*;
#(
    parameter int InVecLength = 64,
    parameter int WorkingRegs = 8,
    parameter int FifoDepth   = 4,
    parameter int LeakShift   = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     in_data_ready,
    input  logic [WorkingRegs*8-1:0] in_data,
    output logic                     req_chunk_in,
    input  logic                     out_ready,
    output logic [WorkingRegs*8-1:0] write_out_data,
    output logic                     write_out_valid,
    output logic                     out_vector_valid
);

    localparam int DW  = WorkingRegs * 8;
    localparam int EW  = DW + 1;
    localparam int CPV = chunks_per_vec(InVecLength, WorkingRegs);
    localparam int IW  = (CPV > 1) ? $clog2(CPV) : 1;
    localparam int CW  = $clog2(FifoDepth) + 1;

`ifdef RELU_LEAKY_EN
    localparam bit Leaky = 1'b1;
`else
    localparam bit Leaky = 1'b0;
`endif

    function automatic int8_t relu_lane(input int8_t x);
        if (x >= 0) begin
            return x;
        end
        return Leaky ? int8_t'(x >>> LeakShift) : int8_t'(0);
    endfunction

    relu_state_t   state;
    logic [IW-1:0] in_chunk_idx;
    logic [DW-1:0] relu_data;
    logic          last_flag;
    logic          accept;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_head;
    logic          head_last;

    always_comb begin
        relu_data = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            relu_data[i*8 +: 8] = relu_lane(int8_t'(in_data[i*8 +: 8]));
        end
    end

    assign req_chunk_in = !rst_in && (fifo_count != CW'(FifoDepth));
    assign accept       = req_chunk_in & in_data_ready & ~fifo_full;
    assign last_flag    = (in_chunk_idx == IW'(CPV - 1));

    // A vector's last chunk returns the FSM to IDLE and wraps the index.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            in_chunk_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && !last_flag) begin
                        state        <= ACCEPT;
                        in_chunk_idx <= in_chunk_idx + 1'b1;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        if (last_flag) begin
                            state        <= IDLE;
                            in_chunk_idx <= '0;
                        end else begin
                            in_chunk_idx <= in_chunk_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_chunk_idx <= '0;
                end
            endcase
        end
    end

    chunk_fifo #(
        .Width (EW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (accept),
        .din    ({last_flag, relu_data}),
        .pop    (fifo_pop),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign head_last        = fifo_head[DW];
    assign write_out_data   = fifo_head[DW-1:0];
    assign write_out_valid  = ~fifo_empty;
    assign fifo_pop         = write_out_valid & out_ready;
    assign out_vector_valid = fifo_pop & head_last;

endmodule

// File: tb/tb_relu_stage.sv
// Self-checking bench for relu_stage against a queue-based reference.
// Build with RELU_LEAKY_EN defined to also exercise the leaky variant.
module tb_relu_stage;

    localparam int L   = 64;
    localparam int W   = 8;
    localparam int D   = 4;
    localparam int S   = 3;
    localparam int CPV = L / W;
    localparam int DW  = W * 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          in_data_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          req_chunk_in;
    logic [DW-1:0] write_out_data;
    logic          write_out_valid;
    logic          out_vector_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW:0] q[$];
    int          m_idx = 0;

    relu_stage #(
        .InVecLength (L),
        .WorkingRegs (W),
        .FifoDepth   (D),
        .LeakShift   (S)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .in_data_ready    (in_data_ready),
        .in_data          (in_data),
        .req_chunk_in     (req_chunk_in),
        .out_ready        (out_ready),
        .write_out_data   (write_out_data),
        .write_out_valid  (write_out_valid),
        .out_vector_valid (out_vector_valid)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [DW-1:0] ref_relu(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < W; i++) begin
            v = $signed(d[i*8 +: 8]);
            if (v < 0) begin
`ifdef RELU_LEAKY_EN
                v = (v - (1 << S) + 1) / (1 << S);
`else
                v = 0;
`endif
            end
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Advance one clock, updating the reference from the current inputs.
    task automatic cycle();
        bit push;
        bit pop;
        logic [DW:0] e;
        push = in_data_ready && (q.size() < D);
        pop  = out_ready && (q.size() > 0);
        e    = {(m_idx == CPV - 1), ref_relu(in_data)};
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(e);
            m_idx = (m_idx + 1) % CPV;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        in_data_ready = 1'b0;
        out_ready     = 1'b0;
        rst_in        = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        q.delete();
        m_idx = 0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        n_checks++;
        if (req_chunk_in !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0", req_chunk_in);
        end
        n_checks++;
        if (write_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", write_out_valid);
        end
        n_checks++;
        if (out_vector_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovv: got %b want 0", out_vector_valid);
        end
        n_checks++;
        if (write_out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", write_out_data);
        end
        rst_in = 1'b0;
        q.delete();
        m_idx = 0;
        #1;
        n_checks++;
        if (req_chunk_in !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_req: got %b want 1", req_chunk_in);
        end
        @(negedge clk_in);
    endtask

    task automatic test_relu_lanes();
        int lanes_in[8];
        int lanes_ex[8];
        logic [DW-1:0] exp_d;
        lanes_in = '{-128, -1, 0, 1, 127, -5, 5, -64};
`ifdef RELU_LEAKY_EN
        lanes_ex = '{-16, -1, 0, 1, 127, -1, 5, -8};
`else
        lanes_ex = '{0, 0, 0, 1, 127, 0, 5, 0};
`endif
        exp_d = '0;
        for (int i = 0; i < W; i++) begin
            in_data[i*8 +: 8] = lanes_in[i][7:0];
            exp_d[i*8 +: 8]   = lanes_ex[i][7:0];
        end
        in_data_ready = 1'b1;
        out_ready     = 1'b1;
        cycle();
        in_data_ready = 1'b0;
        #1;
        n_checks++;
        if (write_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL relu_valid: got %b want 1", write_out_valid);
        end
        n_checks++;
        if (write_out_data !== exp_d) begin
            n_fail++;
            $display("FAIL relu_lanes: got %h want %h", write_out_data, exp_d);
        end
        n_checks++;
        if (q.size() == 0 || write_out_data !== q[0][DW-1:0]) begin
            n_fail++;
            $display("FAIL relu_model: got %h want model head", write_out_data);
        end
        n_checks++;
        if (out_vector_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL relu_ovv: got %b want 0", out_vector_valid);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pulse_at;
        int outs;
        pulses   = 0;
        pulse_at = -1;
        outs     = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < CPV) begin
                in_data_ready = 1'b1;
                in_data       = {$urandom, $urandom};
            end else begin
                in_data_ready = 1'b0;
            end
            #1;
            n_checks++;
            if (write_out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", k, write_out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (write_out_data !== q[0][DW-1:0] || out_vector_valid !== q[0][DW]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", k, write_out_data,
                             out_vector_valid, q[0][DW-1:0], q[0][DW]);
                end
            end
            if (write_out_valid && out_ready) begin
                if (out_vector_valid) begin
                    pulses++;
                    pulse_at = outs;
                end
                outs++;
            end
            cycle();
        end
        n_checks++;
        if (pulses != 1 || pulse_at != CPV - 1 || outs != CPV) begin
            n_fail++;
            $display("FAIL b2b_pulse: got pulses=%0d at=%0d outs=%0d want 1 at %0d outs %0d",
                     pulses, pulse_at, outs, CPV - 1, CPV);
        end
    endtask

    task automatic test_backpressure_full();
        int pushed;
        int popped;
        pushed = 0;
        popped = 0;
        do_reset();
        out_ready     = 1'b0;
        in_data_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = {$urandom, $urandom};
            #1;
            n_checks++;
            if (req_chunk_in !== (k < D)) begin
                n_fail++;
                $display("FAIL bp_req[%0d]: got %b want %b", k, req_chunk_in, k < D);
            end
            if (req_chunk_in) pushed++;
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            in_data_ready = (k < 10);
            in_data       = {$urandom, $urandom};
            #1;
            n_checks++;
            if (req_chunk_in !== (q.size() < D) || write_out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL full_hs[%0d]: got req=%b valid=%b want req=%b valid=%b", k,
                         req_chunk_in, write_out_valid, q.size() < D, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (write_out_data !== q[0][DW-1:0]) begin
                    n_fail++;
                    $display("FAIL full_data[%0d]: got %h want %h", k, write_out_data, q[0][DW-1:0]);
                end
            end
            if (req_chunk_in && in_data_ready) pushed++;
            if (write_out_valid && out_ready) popped++;
            cycle();
        end
        n_checks++;
        if (popped != pushed || write_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_noloss: got popped=%0d valid=%b want %0d and 0",
                     popped, write_out_valid, pushed);
        end
    endtask

    task automatic test_reset_midvector();
        int pulses;
        pulses = 0;
        do_reset();
        in_data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = {$urandom, $urandom};
            cycle();
        end
        in_data_ready = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        n_checks++;
        if (write_out_valid !== 1'b0 || write_out_data !== '0 || req_chunk_in !== 1'b0
            || out_vector_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out: got valid=%b data=%h req=%b ovv=%b want all 0",
                     write_out_valid, write_out_data, req_chunk_in, out_vector_valid);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        q.delete();
        m_idx     = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data_ready = (k < CPV);
            in_data       = {$urandom, $urandom};
            #1;
            if (q.size() != 0) begin
                n_checks++;
                if (write_out_data !== q[0][DW-1:0] || out_vector_valid !== q[0][DW]) begin
                    n_fail++;
                    $display("FAIL midrst_data[%0d]: got %h/%b want %h/%b", k, write_out_data,
                             out_vector_valid, q[0][DW-1:0], q[0][DW]);
                end
            end
            if (out_vector_valid) pulses++;
            cycle();
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL midrst_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_data_ready = ($urandom % 10) < 7;
            out_ready     = ($urandom % 10) < 6;
            in_data       = {$urandom, $urandom};
            #1;
            n_checks++;
            if (req_chunk_in !== (q.size() < D) || write_out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_hs[%0d]: got req=%b valid=%b want req=%b valid=%b", k,
                         req_chunk_in, write_out_valid, q.size() < D, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (write_out_data !== q[0][DW-1:0]
                    || out_vector_valid !== (out_ready & q[0][DW])) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", k, write_out_data,
                             out_vector_valid, q[0][DW-1:0], out_ready & q[0][DW]);
                end
            end else begin
                n_checks++;
                if (out_vector_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_ovv_empty[%0d]: got %b want 0", k, out_vector_valid);
                end
            end
            cycle();
        end
    endtask

`ifdef RELU_LEAKY_EN
    task automatic test_leaky();
        int lanes_in[4];
        int lanes_ex[4];
        logic [DW-1:0] exp_d;
        lanes_in = '{-128, -8, -1, 7};
        lanes_ex = '{-16, -1, -1, 7};
        do_reset();
        in_data = '0;
        exp_d   = '0;
        for (int i = 0; i < 4; i++) begin
            in_data[i*8 +: 8] = lanes_in[i][7:0];
            exp_d[i*8 +: 8]   = lanes_ex[i][7:0];
        end
        in_data_ready = 1'b1;
        out_ready     = 1'b1;
        cycle();
        in_data_ready = 1'b0;
        #1;
        n_checks++;
        if (write_out_data !== exp_d || write_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL leaky_lanes: got %h/%b want %h/1", write_out_data, write_out_valid, exp_d);
        end
        cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_relu_lanes();
        test_back_to_back();
        test_backpressure_full();
        test_reset_midvector();
        test_random();
`ifdef RELU_LEAKY_EN
        test_leaky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
